// File: rtl/p405s_icu_fill_addr_seq.sv
// ICU line-fill address sequencer: one PLB line-read request per miss, then one word address per data beat.
// Define P405S_ICU_FILL_CWF_EN to start at the missed word and wrap (critical word first); otherwise fills start at offset 0.
module p405s_icu_fill_addr_seq #(
    parameter int LOG2_WORDS = 3
) (
    input  logic        CB,
    input  logic        reset,
    input  logic        missReq,
    input  logic [0:31] missAddr,
    input  logic        cancel,
    input  logic        plbAck,
    input  logic        plbRdDAck,
    input  logic        plbErr,
    output logic        reqVal,
    output logic [0:31] reqAddr,
    output logic [0:31] fillAddr,
    output logic        fillAddrE1,
    output logic        busy,
    output logic        fillDone,
    output logic        fillErr
);

    localparam int                    WORDS    = 1 << LOG2_WORDS;
    localparam logic [0:31]           OFS_MASK = 32'((WORDS - 1) << 2);
    localparam logic [0:31]           WORD_MSK = 32'hFFFF_FFFC;
    localparam logic [LOG2_WORDS-1:0] CNT_ONE  = LOG2_WORDS'(1);
    localparam logic [LOG2_WORDS-1:0] CNT_LAST = {LOG2_WORDS{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [0:31]           fill_addr_q, fill_addr_d;
    logic [0:31]           req_addr_q, req_addr_d;
    logic [LOG2_WORDS-1:0] cnt_q, cnt_d;
    logic                  busy_q, req_val_q, done_q, err_q;
    logic                  done_d, err_d;
    logic                  last_s;

    // Offset field steps modulo the line; tag/index bits never see a carry.
    function automatic logic [0:31] next_ptr(input logic [0:31] ptr);
        return (ptr & ~OFS_MASK) | ((ptr + 32'd4) & OFS_MASK);
    endfunction

    function automatic logic [0:31] start_ptr(input logic [0:31] addr);
`ifdef P405S_ICU_FILL_CWF_EN
        return addr & WORD_MSK;
`else
        return addr & WORD_MSK & ~OFS_MASK;
`endif
    endfunction

    assign last_s = (cnt_q == CNT_LAST);

    // Next-state, pointer and beat-counter logic; plbErr outranks cancel, which outranks ack/beats.
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        req_addr_d  = req_addr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (missReq) begin
                    state_d     = S_REQ;
                    req_addr_d  = start_ptr(missAddr);
                    fill_addr_d = start_ptr(missAddr);
                    cnt_d       = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (plbErr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (plbAck) begin
                    state_d = cancel ? S_DRAIN : S_DATA;
                end else if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DATA: begin
                if (plbErr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (plbRdDAck) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!cancel) begin
                        fill_addr_d = next_ptr(fill_addr_q);
                    end else begin
                        fill_addr_d = fill_addr_q;
                    end
                    if (last_s) begin
                        state_d = S_IDLE;
                        done_d  = ~cancel;
                    end else begin
                        state_d = cancel ? S_DRAIN : S_DATA;
                    end
                end else if (cancel) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DRAIN: begin
                if (plbErr) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (plbRdDAck) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = last_s ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any fill in progress.
    always_ff @(posedge CB) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fill_addr_q <= 32'h0000_0000;
            req_addr_q  <= 32'h0000_0000;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            req_val_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d != S_IDLE);
            req_val_q   <= (state_d == S_REQ);
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Load enable is combinational so the datapath register captures fillAddr on the beat edge itself.
    assign fillAddrE1 = plbRdDAck & (state_q == S_DATA) & ~cancel & ~plbErr & ~reset;
    assign fillAddr   = fill_addr_q;
    assign reqAddr    = req_addr_q;
    assign reqVal     = req_val_q;
    assign busy       = busy_q;
    assign fillDone   = done_q;
    assign fillErr    = err_q;

endmodule
